// File: rtl/brp_pkg.sv
// Shared definitions for the branch resolver: funct3 codes and 2-bit counter states.
package brp_pkg;

    // Conditional branch funct3 encodings
    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    // Two-bit saturating prediction counter; MSB is the taken prediction
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_ctr_e;

    // Saturating counter step: taken moves toward ST, not-taken toward SNT
    function automatic bht_ctr_e ctr_next(input bht_ctr_e c, input logic taken);
        bht_ctr_e n;
        n = c;
        case (c)
            SNT:     n = taken ? WNT : SNT;
            WNT:     n = taken ? WT  : SNT;
            WT:      n = taken ? ST  : WNT;
            ST:      n = taken ? ST  : WT;
            default: n = WNT;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/bht.sv
// Branch history table: array of 2-bit counters, one async read port, one sync update port.
module bht
    import brp_pkg::*;
#(
    parameter int unsigned BHT_ENTRIES = 16,
    parameter int unsigned IDX_W       = $clog2(BHT_ENTRIES)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [IDX_W-1:0] i_rd_idx,
    output bht_ctr_e         o_rd_ctr,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic             i_wr_taken
);

    bht_ctr_e r_table [BHT_ENTRIES];

    // Counter array: reset to WNT wins over any pending update
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < int'(BHT_ENTRIES); i++) begin
                r_table[i] <= WNT;
            end
        end else if (i_wr_en) begin
            r_table[i_wr_idx] <= ctr_next(r_table[i_wr_idx], i_wr_taken);
        end
    end

    // Read returns the stored value; a same-cycle update is not bypassed
    assign o_rd_ctr = r_table[i_rd_idx];

endmodule

// File: rtl/branch_resolver.sv
// Branch resolver: decodes conditional branch outcomes, flags mispredictions,
// keeps statistics and trains a 2-bit counter prediction table.
module branch_resolver
    import brp_pkg::*;
#(
    parameter int unsigned BHT_ENTRIES = 16,
    parameter int unsigned IDX_W       = $clog2(BHT_ENTRIES)
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_if_pc,
    output logic        o_pred_taken,
    input  logic        i_ex_valid,
    input  logic [31:0] i_ex_pc,
    input  logic [2:0]  i_ex_funct3,
    input  logic        i_ex_pred_taken,
    output logic        o_br_un,
    input  logic        i_br_less,
    input  logic        i_br_equal,
    output logic        o_taken,
    output logic        o_mispredict,
    output logic        o_illegal,
    output logic [31:0] o_br_cnt,
    output logic [31:0] o_mispred_cnt
);

    logic             w_br_un;
    logic             w_legal;
    logic             w_cond;
    logic             w_resolve;
    logic             w_taken;
    logic             w_mispredict;
    logic [IDX_W-1:0] w_rd_idx;
    logic [IDX_W-1:0] w_wr_idx;
    bht_ctr_e         w_rd_ctr;
    logic [31:0]      r_br_cnt;
    logic [31:0]      r_mispred_cnt;

    // Word-aligned PCs: drop the two low bits before indexing
    assign w_rd_idx = i_if_pc[IDX_W+1:2];
    assign w_wr_idx = i_ex_pc[IDX_W+1:2];

    // Decode funct3 into comparator mode, legality and raw branch condition
    always_comb begin
        w_br_un = 1'b1;
        w_legal = 1'b1;
        w_cond  = 1'b0;
        case (i_ex_funct3)
            BEQ:  w_cond = i_br_equal;
            BNE:  w_cond = !i_br_equal;
            BLT:  w_cond = i_br_less;
            BGE:  w_cond = !i_br_less;
            BLTU: begin
                w_br_un = 1'b0;
                w_cond  = i_br_less;
            end
            BGEU: begin
                w_br_un = 1'b0;
                w_cond  = !i_br_less;
            end
            default: w_legal = 1'b0;
        endcase
    end

    // Resolution outputs, all gated by a valid legal branch in EX
    always_comb begin
        w_resolve    = i_ex_valid && w_legal;
        w_taken      = w_resolve && w_cond;
        w_mispredict = w_resolve && (w_cond ^ i_ex_pred_taken);
    end

    assign o_br_un      = w_br_un;
    assign o_taken      = w_taken;
    assign o_mispredict = w_mispredict;
    assign o_illegal    = i_ex_valid && !w_legal;

    bht #(
        .BHT_ENTRIES (BHT_ENTRIES),
        .IDX_W       (IDX_W)
    ) u_bht (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_rd_idx   (w_rd_idx),
        .o_rd_ctr   (w_rd_ctr),
        .i_wr_en    (w_resolve),
        .i_wr_idx   (w_wr_idx),
        .i_wr_taken (w_cond)
    );

    assign o_pred_taken = w_rd_ctr[1];

    // Statistics counters; free-running 32-bit wrap
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_br_cnt      <= 32'd0;
            r_mispred_cnt <= 32'd0;
        end else if (w_resolve) begin
            r_br_cnt <= r_br_cnt + 32'd1;
            if (w_mispredict) begin
                r_mispred_cnt <= r_mispred_cnt + 32'd1;
            end
        end
    end

    assign o_br_cnt      = r_br_cnt;
    assign o_mispred_cnt = r_mispred_cnt;

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: directed literal cases, then random traffic
// checked against a behavioural model of the prediction table and statistics.
module tb_branch_resolver;

    localparam int unsigned ENTRIES = 16;

    logic        clk = 1'b0;
    logic        i_reset = 1'b0;
    logic [31:0] i_if_pc = '0;
    logic        o_pred_taken;
    logic        i_ex_valid = 1'b0;
    logic [31:0] i_ex_pc = '0;
    logic [2:0]  i_ex_funct3 = '0;
    logic        i_ex_pred_taken = 1'b0;
    logic        o_br_un;
    logic        i_br_less = 1'b0;
    logic        i_br_equal = 1'b0;
    logic        o_taken;
    logic        o_mispredict;
    logic        o_illegal;
    logic [31:0] o_br_cnt;
    logic [31:0] o_mispred_cnt;

    branch_resolver #(.BHT_ENTRIES(ENTRIES)) dut (
        .i_clk           (clk),
        .i_reset         (i_reset),
        .i_if_pc         (i_if_pc),
        .o_pred_taken    (o_pred_taken),
        .i_ex_valid      (i_ex_valid),
        .i_ex_pc         (i_ex_pc),
        .i_ex_funct3     (i_ex_funct3),
        .i_ex_pred_taken (i_ex_pred_taken),
        .o_br_un         (o_br_un),
        .i_br_less       (i_br_less),
        .i_br_equal      (i_br_equal),
        .o_taken         (o_taken),
        .o_mispredict    (o_mispredict),
        .o_illegal       (o_illegal),
        .o_br_cnt        (o_br_cnt),
        .o_mispred_cnt   (o_mispred_cnt)
    );

    always #5 clk = ~clk;

    // Model state: counter values 0..3 and the two statistics
    int unsigned m_ctr [ENTRIES];
    logic [31:0] m_br = '0;
    logic [31:0] m_mis = '0;
    bit          m_valid = 1'b0;  // model known only after first reset

    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

    // DUT samples from the most recent cycle, for literal checks
    logic s_pred, s_un, s_taken, s_mis, s_ill;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned idx_of(input logic [31:0] pc);
        return (pc >> 2) % ENTRIES;
    endfunction

    // One clock: drive at negedge, check combinational outputs, advance model at posedge
    task automatic cycle(input logic rst, input logic [31:0] ifpc, input logic v,
                         input logic [31:0] pc, input logic [2:0] f3, input logic pr,
                         input logic lt, input logic eq);
        bit legal, cond, e_un;
        @(negedge clk);
        i_reset = rst; i_if_pc = ifpc; i_ex_valid = v; i_ex_pc = pc;
        i_ex_funct3 = f3; i_ex_pred_taken = pr; i_br_less = lt; i_br_equal = eq;
        #1;
        legal = !(f3 == 3'd2 || f3 == 3'd3);
        e_un  = !(f3 == 3'd6 || f3 == 3'd7);
        if (f3 == 3'd0) cond = eq;
        else if (f3 == 3'd1) cond = !eq;
        else if (f3 == 3'd4 || f3 == 3'd6) cond = lt;
        else cond = !lt;
        s_pred = o_pred_taken; s_un = o_br_un; s_taken = o_taken;
        s_mis = o_mispredict; s_ill = o_illegal;
        if (m_valid) chk("pred_taken", {31'd0, o_pred_taken}, {31'd0, m_ctr[idx_of(ifpc)] >= 2});
        chk("br_un", {31'd0, o_br_un}, {31'd0, e_un});
        chk("taken", {31'd0, o_taken}, {31'd0, v && legal && cond});
        chk("mispredict", {31'd0, o_mispredict}, {31'd0, v && legal && (cond != pr)});
        chk("illegal", {31'd0, o_illegal}, {31'd0, v && !legal});
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < int'(ENTRIES); i++) m_ctr[i] = 1;
            m_br = 0; m_mis = 0; m_valid = 1'b1;
        end else if (v && legal) begin
            if (cond && m_ctr[idx_of(pc)] < 3) m_ctr[idx_of(pc)]++;
            if (!cond && m_ctr[idx_of(pc)] > 0) m_ctr[idx_of(pc)]--;
            m_br++;
            if (cond != pr) m_mis++;
        end
        #1;
        if (m_valid) begin
            chk("br_cnt", o_br_cnt, m_br);
            chk("mispred_cnt", o_mispred_cnt, m_mis);
        end
        i_ex_valid = 1'b0; i_reset = 1'b0;
    endtask

    // Idle cycle used as a prediction lookup
    task automatic lookup(input logic [31:0] pc, output logic p);
        cycle(1'b0, pc, 1'b0, 32'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        p = s_pred;
    endtask

    logic p;

    initial begin
        // Reset state
        cycle(1'b1, 32'h10, 1'b0, 32'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        lookup(32'h0, p);         chk("rst_pred_0", {31'd0, p}, 32'd0);
        lookup(32'h10, p);        chk("rst_pred_10", {31'd0, p}, 32'd0);
        lookup(32'hFFFF_FFFC, p); chk("rst_pred_top", {31'd0, p}, 32'd0);
        chk("rst_br_cnt", o_br_cnt, 32'd0);
        chk("rst_mis_cnt", o_mispred_cnt, 32'd0);

        // Taken BEQ training at 0x10 and saturation at ST
        cycle(1'b0, 32'h0, 1'b1, 32'h10, 3'd0, 1'b0, 1'b0, 1'b1);
        chk("beq1_mis", {31'd0, s_mis}, 32'd1);
        chk("beq1_taken", {31'd0, s_taken}, 32'd1);
        lookup(32'h10, p);        chk("beq1_pred", {31'd0, p}, 32'd1);
        cycle(1'b0, 32'h0, 1'b1, 32'h10, 3'd0, 1'b1, 1'b0, 1'b1);
        chk("beq2_mis", {31'd0, s_mis}, 32'd0);
        chk("beq2_mis_cnt", o_mispred_cnt, 32'd1);
        chk("beq2_br_cnt", o_br_cnt, 32'd2);
        cycle(1'b0, 32'h0, 1'b1, 32'h10, 3'd0, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b1, 32'h10, 3'd0, 1'b1, 1'b0, 1'b0);
        lookup(32'h10, p);        chk("sat_st_pred", {31'd0, p}, 32'd1);
        cycle(1'b0, 32'h0, 1'b1, 32'h10, 3'd0, 1'b1, 1'b0, 1'b0);
        lookup(32'h10, p);        chk("sat_wnt_pred", {31'd0, p}, 32'd0);
        chk("sat_mis_cnt", o_mispred_cnt, 32'd3);

        // Unsigned / signed comparator modes
        cycle(1'b0, 32'h0, 1'b1, 32'h20, 3'b110, 1'b0, 1'b1, 1'b0);
        chk("bltu_un", {31'd0, s_un}, 32'd0);
        chk("bltu_taken", {31'd0, s_taken}, 32'd1);
        cycle(1'b0, 32'h0, 1'b1, 32'h20, 3'b101, 1'b0, 1'b1, 1'b0);
        chk("bge_un", {31'd0, s_un}, 32'd1);
        chk("bge_taken", {31'd0, s_taken}, 32'd0);

        // Illegal funct3
        cycle(1'b0, 32'h0, 1'b1, 32'h20, 3'b011, 1'b1, 1'b1, 1'b1);
        chk("ill_flag", {31'd0, s_ill}, 32'd1);
        chk("ill_taken", {31'd0, s_taken}, 32'd0);
        chk("ill_br_cnt", o_br_cnt, 32'd7);

        // Same-cycle update and lookup at 0x40: no bypass
        cycle(1'b0, 32'h40, 1'b1, 32'h40, 3'd0, 1'b0, 1'b0, 1'b1);
        chk("rw_old", {31'd0, s_pred}, 32'd0);
        lookup(32'h40, p);        chk("rw_new", {31'd0, p}, 32'd1);

        // Statistics wrap, then reset overriding a resolving branch
        @(negedge clk);
        dut.r_br_cnt = 32'hFFFF_FFFF; m_br = 32'hFFFF_FFFF;
        cycle(1'b0, 32'h0, 1'b1, 32'h44, 3'd1, 1'b1, 1'b0, 1'b0);
        chk("wrap_br_cnt", o_br_cnt, 32'd0);
        @(negedge clk);
        dut.r_br_cnt = 32'hFFFF_FFFF; m_br = 32'hFFFF_FFFF;
        cycle(1'b1, 32'h0, 1'b1, 32'h10, 3'd0, 1'b0, 1'b0, 1'b1);
        chk("rstpri_br_cnt", o_br_cnt, 32'd0);
        chk("rstpri_mis_cnt", o_mispred_cnt, 32'd0);
        lookup(32'h40, p);        chk("rstpri_pred_40", {31'd0, p}, 32'd0);
        lookup(32'h10, p);        chk("rstpri_pred_10", {31'd0, p}, 32'd0);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] ipc, epc;
            logic pr;
            ipc = {$urandom_range(0, 3), 4'd0, 4'($urandom_range(0, 15)), 2'b00};
            epc = {$urandom_range(0, 3), 4'd0, 4'($urandom_range(0, 15)), 2'b00};
            pr  = ($urandom_range(0, 1) == 1) ? (m_ctr[idx_of(epc)] >= 2) : 1'($urandom);
            cycle(($urandom_range(0, 99) == 0), ipc, ($urandom_range(0, 3) != 0), epc,
                  3'($urandom), pr, 1'($urandom), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
